// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - USB RX bit timing recovery, NRZI decode and bit de-stuffing
//
// Re-phases a per-bit clock counter on every D+ transition, strobes the line
// mid-bit, NRZI-decodes the sample, drops stuffed bits and counts bits into bytes.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   enable        in   receive window; low clears all state
//   d_edge        in   one-cycle pulse on any D+ transition
//   d_line        in   synchronized D+ level, aligned with d_edge
//   shift_enable  out  combinational mid-bit sample strobe
//   bit_valid     out  pulse: rcv_bit holds a decoded data bit
//   rcv_bit       out  decoded bit, held between bit_valid pulses
//   byte_received out  pulse with the 8th bit_valid of a byte
//   stuff_err     out  pulse: stuff-bit position decoded as 1
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 4,
    parameter int STUFF_RUN    = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic d_edge,
    input  logic d_line,
    output logic shift_enable,
    output logic bit_valid,
    output logic rcv_bit,
    output logic byte_received,
    output logic stuff_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_RUN + 1);

    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [OW-1:0] ones_cnt;
    logic          prev_sample;
    logic          sample_dec;

    // An edge landing on the sample phase re-phases the counter, so that
    // strobe would sit on the transition and is suppressed.
    assign shift_enable = enable & (clk_cnt == CW'(SAMPLE_PHASE)) & ~d_edge;

    // NRZI: no change from the previous sample decodes as 1.
    assign sample_dec = ~(d_line ^ prev_sample);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            ones_cnt      <= '0;
            prev_sample   <= 1'b1;
            bit_valid     <= 1'b0;
            rcv_bit       <= 1'b0;
            byte_received <= 1'b0;
            stuff_err     <= 1'b0;
        end else begin
            // The edge cycle counts as phase 0, so the next cycle is phase 1.
            if (d_edge) begin
                clk_cnt <= CW'(1);
            end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            bit_valid     <= 1'b0;
            byte_received <= 1'b0;
            stuff_err     <= 1'b0;

            if (shift_enable) begin
                prev_sample <= d_line;
                if (ones_cnt == OW'(STUFF_RUN)) begin
                    // Stuff position: must decode as 0; never reaches the byte.
                    ones_cnt  <= '0;
                    stuff_err <= sample_dec;
                end else begin
                    bit_valid     <= 1'b1;
                    rcv_bit       <= sample_dec;
                    ones_cnt      <= sample_dec ? ones_cnt + 1'b1 : '0;
                    bit_cnt       <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
                    byte_received <= (bit_cnt == 3'd7);
                end
            end
        end
    end

endmodule
